hazard_ctrl: RTL and testbench

Parametrised, sequential hazard-detection and stall controller for the pipelined core, sitting beside the IF/ID register and driving pipeline stall and bubble controls. Instead of comparing raw destination fields from downstream pipeline registers, it keeps its own scoreboard: a shift register of in-flight destination tags with valid bits. It also adds a PC-hazard state machine with timeout for `ret` and `branch` instructions, plus a stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard-detection and stall controller beside the IF/ID register: a tag scoreboard
// for read-after-write conflicts plus a PC-wait FSM for ret/branch with timeout.
`timescale 1ns/1ps
module hazard_ctrl #(
    parameter int REG_W        = 4,
    parameter int SRC_PORTS    = 3,
    parameter int DEPTH        = 3,
    parameter int DATA_SEG_REG = 14,
    parameter int ZERO_REG_EN  = 1,
    parameter int PC_TIMEOUT   = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [SRC_PORTS*REG_W-1:0] id_src,
    input  logic [SRC_PORTS-1:0]       id_src_en,
    input  logic                       id_data_reg,
    input  logic [REG_W-1:0]           id_dst,
    input  logic                       id_we,
    input  logic                       id_ret,
    input  logic                       id_branch,
    input  logic                       id_call,
    input  logic                       pc_update,
    output logic                       data_hazard,
    output logic                       pc_hazard,
    output logic                       bubble,
    output logic                       timeout_err,
    output logic [15:0]                stall_cnt,
    output logic                       o_dbg_state
);

    localparam int CNT_W = (PC_TIMEOUT > 1) ? $clog2(PC_TIMEOUT) : 1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WAIT_PC = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_pc_cnt;
    logic [CNT_W-1:0]   w_pc_cnt_nxt;
    logic               w_timeout_hit;
    logic               r_timeout_err;
    logic [15:0]        r_stall_cnt;
    logic [DEPTH-1:0]   r_tag_v;
    logic [REG_W-1:0]   r_tag_dst [DEPTH];

    logic [REG_W-1:0]   w_src [SRC_PORTS];
    logic               w_raw;
    logic               w_idle;
    logic               w_issue;
    logic               w_tag_in_v;
    logic               w_unused;

    // Calls resolve their target without a PC wait, so the class bit is not consumed.
    assign w_unused = id_call;

    always_comb begin
        for (int k = 0; k < SRC_PORTS; k++) begin
            w_src[k] = id_src[k*REG_W +: REG_W];
        end
        if (id_data_reg) begin
            w_src[0] = REG_W'(DATA_SEG_REG);
        end
    end

    // Only older in-flight tags are compared, so an instruction never hazards on itself.
    always_comb begin
        w_raw = 1'b0;
        for (int k = 0; k < SRC_PORTS; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (id_src_en[k] && r_tag_v[i] && (w_src[k] == r_tag_dst[i]) &&
                    !((ZERO_REG_EN != 0) && (w_src[k] == '0))) begin
                    w_raw = 1'b1;
                end
            end
        end
    end

    assign w_idle      = (r_state == ST_IDLE);
    assign data_hazard = !rst && id_valid && w_idle && w_raw;
    assign pc_hazard   = !rst && !w_idle;
    assign bubble      = data_hazard || pc_hazard;
    assign w_issue     = !rst && id_valid && w_idle && !w_raw;
    assign w_tag_in_v  = w_issue && id_we && !((ZERO_REG_EN != 0) && (id_dst == '0));

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_cnt_nxt  = r_pc_cnt;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_issue && (id_ret || id_branch)) begin
                    w_state_nxt  = ST_WAIT_PC;
                    w_pc_cnt_nxt = '0;
                end
            end
            ST_WAIT_PC: begin
                if (pc_update) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_pc_cnt == CNT_W'(PC_TIMEOUT - 1)) begin
                    w_state_nxt   = ST_IDLE;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_pc_cnt_nxt = r_pc_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pc_cnt      <= '0;
            r_timeout_err <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc_cnt      <= w_pc_cnt_nxt;
            r_timeout_err <= r_timeout_err || w_timeout_hit;
            if (bubble && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    // Tags shift every cycle, including stalls and PC waits, so producers age out on time.
    always_ff @(posedge clk) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
            r_tag_v[i]   <= rst ? 1'b0 : r_tag_v[i-1];
            r_tag_dst[i] <= r_tag_dst[i-1];
        end
        r_tag_v[0]   <= rst ? 1'b0 : w_tag_in_v;
        r_tag_dst[0] <= id_dst;
    end

    assign timeout_err = r_timeout_err;
    assign stall_cnt   = r_stall_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic, all checked by a
// scoreboard fed from a cycle-level reference model of the hazard and PC-wait rules.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  localparam int REG_W        = 4;
  localparam int SRC_PORTS    = 3;
  localparam int DEPTH        = 3;
  localparam int DATA_SEG_REG = 14;
  localparam int PC_TIMEOUT   = 15;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        tb_rst   = 1'b1;
  logic        tb_valid = 1'b0;
  logic [11:0] tb_src   = '0;
  logic [2:0]  tb_en    = '0;
  logic        tb_dr    = 1'b0;
  logic [3:0]  tb_dst   = '0;
  logic        tb_we    = 1'b0;
  logic        tb_ret   = 1'b0;
  logic        tb_br    = 1'b0;
  logic        tb_call  = 1'b0;
  logic        tb_pu    = 1'b0;

  logic        data_hazard, pc_hazard, bubble, timeout_err, dbg_state;
  logic [15:0] stall_cnt;

  hazard_ctrl #(
    .REG_W(REG_W), .SRC_PORTS(SRC_PORTS), .DEPTH(DEPTH),
    .DATA_SEG_REG(DATA_SEG_REG), .ZERO_REG_EN(1), .PC_TIMEOUT(PC_TIMEOUT)
  ) dut (
    .clk(clk), .rst(tb_rst), .id_valid(tb_valid), .id_src(tb_src),
    .id_src_en(tb_en), .id_data_reg(tb_dr), .id_dst(tb_dst), .id_we(tb_we),
    .id_ret(tb_ret), .id_branch(tb_br), .id_call(tb_call), .pc_update(tb_pu),
    .data_hazard(data_hazard), .pc_hazard(pc_hazard), .bubble(bubble),
    .timeout_err(timeout_err), .stall_cnt(stall_cnt), .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_err    = 0;

  // scoreboard: {dbg_state, data_hazard, pc_hazard, bubble, timeout_err, stall_cnt}
  logic [20:0] exp_q[$];

  // reference model: in-flight writes remembered by issue cycle
  typedef struct {
    int rg;
    int cyc;
  } wr_t;

  wr_t m_wq[$];
  int  m_cyc        = 0;
  bit  m_wait       = 0;
  int  m_wait_start = 0;
  bit  m_err        = 0;
  int  m_cnt        = 0;

  task automatic model_cycle();
    bit raw, e_dh, e_ph, e_b, issue;
    int s, age;
    raw = 0;
    for (int k = 0; k < SRC_PORTS; k++) begin
      s = int'(tb_src[k*REG_W +: REG_W]);
      if (k == 0 && tb_dr) s = DATA_SEG_REG;
      if (tb_en[k] && s != 0) begin
        foreach (m_wq[j]) begin
          age = m_cyc - m_wq[j].cyc;
          if (m_wq[j].rg == s && age >= 1 && age <= DEPTH) raw = 1;
        end
      end
    end
    e_dh  = !tb_rst && tb_valid && !m_wait && raw;
    e_ph  = !tb_rst && m_wait;
    e_b   = e_dh || e_ph;
    issue = !tb_rst && tb_valid && !m_wait && !raw;
    exp_q.push_back({m_wait, e_dh, e_ph, e_b, m_err, 16'(m_cnt)});

    if (tb_rst) begin
      m_wq.delete();
      m_wait = 0;
      m_err  = 0;
      m_cnt  = 0;
    end else begin
      if (e_b && m_cnt < 65535) m_cnt++;
      if (m_wait) begin
        if (tb_pu) m_wait = 0;
        else if (m_cyc - m_wait_start == PC_TIMEOUT - 1) begin
          m_wait = 0;
          m_err  = 1;
        end
      end else if (issue && (tb_ret || tb_br)) begin
        m_wait       = 1;
        m_wait_start = m_cyc + 1;
      end
      if (issue && tb_we && tb_dst != 0) m_wq.push_back('{int'(tb_dst), m_cyc});
    end
    while (m_wq.size() > 0 && (m_cyc + 1 - m_wq[0].cyc) > DEPTH) void'(m_wq.pop_front());
    m_cyc++;
  endtask

  // driver tasks
  task automatic step(input logic r, input logic v, input logic [11:0] src,
                      input logic [2:0] en, input logic dr, input logic [3:0] dst,
                      input logic we, input logic rt, input logic br,
                      input logic cl, input logic pu);
    @(posedge clk);
    #1;
    tb_rst = r; tb_valid = v; tb_src = src; tb_en = en; tb_dr = dr;
    tb_dst = dst; tb_we = we; tb_ret = rt; tb_br = br; tb_call = cl; tb_pu = pu;
    model_cycle();
  endtask

  task automatic idle_step(input logic pu);
    step(1'b0, 1'b0, 12'h0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, pu);
  endtask

  task automatic rand_step(input logic r);
    logic [3:0] dst;
    dst = ($urandom_range(0, 7) == 0) ? 4'd14 : 4'($urandom_range(0, 7));
    step(r, ($urandom_range(0, 3) != 0),
         {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))},
         3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), dst,
         1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
         ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
         ($urandom_range(0, 5) == 0));
  endtask

  task automatic observe();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: compare every presented cycle against the queued expectation
  initial begin
    logic [20:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {dbg_state, data_hazard, pc_hazard, bubble, timeout_err, stall_cnt};
        n_checks++;
        if (act_v !== exp_v) begin
          n_err++;
          $display("FAIL cycle_outputs @%0t: got st/dh/ph/bub/err=%b cnt=%0d expected %b cnt=%0d",
                   $time, act_v[20:16], act_v[15:0], exp_v[20:16], exp_v[15:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;

    // reset with random inputs
    repeat (2) rand_step(1'b1);
    observe();
    chk("reset_flags", int'({data_hazard, pc_hazard, bubble, timeout_err}), 0);
    chk("reset_stall_cnt", int'(stall_cnt), 0);

    // RAW: write r5, then read r5 on port 1
    step(1'b0, 1'b1, 12'h000, 3'b000, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    repeat (4) begin
      step(1'b0, 1'b1, {4'd0, 4'd5, 4'd0}, 3'b010, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      observe();
      cnt += int'(data_hazard);
    end
    chk("raw_stall_cycles", cnt, 3);
    idle_step(1'b0);
    observe();
    chk("raw_stall_cnt", int'(stall_cnt), 3);

    // register 0 never hazards
    step(1'b0, 1'b1, 12'h000, 3'b000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 12'h000, 3'b001, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    observe();
    chk("r0_no_stall", int'(data_hazard), 0);

    // a non-writing producer leaves no tag
    step(1'b0, 1'b1, 12'h000, 3'b000, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, {4'd7, 4'd0, 4'd0}, 3'b100, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    observe();
    chk("we0_no_stall", int'(data_hazard), 0);

    // data-segment register substitution on port 0
    step(1'b0, 1'b1, 12'h000, 3'b000, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    repeat (4) begin
      step(1'b0, 1'b1, {4'd0, 4'd0, 4'd2}, 3'b001, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      observe();
      cnt += int'(data_hazard);
    end
    chk("datareg_stall_cycles", cnt, 3);
    step(1'b0, 1'b1, 12'h000, 3'b000, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, {4'd0, 4'd0, 4'd2}, 3'b001, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    observe();
    chk("datareg_off_no_stall", int'(data_hazard), 0);

    // ret, pc_update four cycles later
    step(1'b0, 1'b1, 12'h000, 3'b000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      idle_step(i == 3);
      observe();
      cnt += int'(pc_hazard);
    end
    chk("ret_wait_cycles", cnt, 4);
    chk("ret_released", int'(pc_hazard), 0);

    // call never waits
    step(1'b0, 1'b1, 12'h000, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cnt = 0;
    repeat (3) begin
      idle_step(1'b0);
      observe();
      cnt += int'(pc_hazard);
    end
    chk("call_no_wait", cnt, 0);

    // branch with no pc_update times out
    step(1'b0, 1'b1, 12'h000, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cnt = 0;
    repeat (18) begin
      idle_step(1'b0);
      observe();
      cnt += int'(pc_hazard);
    end
    chk("timeout_wait_cycles", cnt, PC_TIMEOUT);
    chk("timeout_err_set", int'(timeout_err), 1);
    idle_step(1'b1);
    idle_step(1'b0);
    observe();
    chk("timeout_err_sticky", int'(timeout_err), 1);

    // reset in the middle of a PC wait
    step(1'b1, 1'b0, 12'h000, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 12'h000, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) idle_step(1'b0);
    observe();
    chk("midwait_pc_hazard", int'(pc_hazard), 1);
    step(1'b1, 1'b1, 12'h000, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    observe();
    chk("rst_forces_pc_hazard_low", int'(pc_hazard), 0);
    idle_step(1'b0);
    observe();
    chk("after_rst_idle", int'({dbg_state, pc_hazard, timeout_err}), 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rand_step($urandom_range(0, 199) == 0);
    end

    idle_step(1'b0);
    observe();
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
